// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file: operand reads, writeback, issue and scoreboard status.
// Read port i occupies the i-th ADDR_W / DATA_W slice of the flat read vectors.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic [ADDR_W:0]          busy_cnt;
    logic                     waw_err;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_cnt, waw_err
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_cnt, waw_err
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-through bypass and a per-register busy scoreboard.
// Reads are combinational; writes, busy bits, busy count and the sticky WAW flag update on clk.
module regfile_sb_rd_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] reg_q,
    input  logic              busy_q,
    output logic [DATA_W-1:0] data,
    output logic              busy
);
    localparam bit ZR = (ZERO_REG != 0);

    // A register being written back this cycle is already resolved: forward it, not busy.
    always_comb begin
        data = reg_q;
        busy = busy_q;
        if (ZR && addr == '0) begin
            data = '0;
            busy = 1'b0;
        end else if (wr_en && wr_addr == addr) begin
            data = wr_data;
            busy = 1'b0;
        end
    end
endmodule

module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input logic        clk,
    input logic        reset,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt;
    logic [ADDR_W:0]   cnt_q, cnt_nxt;
    logic              waw_q, waw_hit, wr_ok;

    assign wr_ok = bus.wr_en && !(ZR && bus.wr_addr == '0);

    // Issue wins over writeback on the same register: the new producer owns it.
    always_comb begin
        busy_nxt = busy;
        if (bus.wr_en)  busy_nxt[bus.wr_addr]  = 1'b0;
        if (bus.iss_en) busy_nxt[bus.iss_addr] = 1'b1;
        if (ZR)         busy_nxt[0]            = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < DEPTH; r++)
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[r]};
    end

    assign waw_hit = bus.iss_en && busy[bus.iss_addr]
                   && !(bus.wr_en && bus.wr_addr == bus.iss_addr)
                   && !(ZR && bus.iss_addr == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
            busy  <= '0;
            cnt_q <= '0;
            waw_q <= 1'b0;
        end else begin
            if (wr_ok) regs[bus.wr_addr] <= bus.wr_data;
            busy  <= busy_nxt;
            cnt_q <= cnt_nxt;
            if (waw_hit) waw_q <= 1'b1;
        end
    end

    assign bus.busy_cnt = cnt_q;
    assign bus.waw_err  = waw_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];

        regfile_sb_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_port (
            .addr   (addr),
            .wr_en  (bus.wr_en),
            .wr_addr(bus.wr_addr),
            .wr_data(bus.wr_data),
            .reg_q  (regs[addr]),
            .busy_q (busy[addr]),
            .data   (data),
            .busy   (bsy)
        );

        assign bus.rd_data[i*DATA_W +: DATA_W] = data;
        assign bus.rd_busy[i]                  = bsy;
    end
endmodule
